// File: rtl/code_lock_ctrl_pkg.sv
// Shared types and constants for the code lock controller.
// The PROGRAM state exists only when CODE_LOCK_PROGRAM_EN is defined.
package code_lock_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_ENTRY,
    ST_OPEN,
    ST_LOCKOUT
`ifdef CODE_LOCK_PROGRAM_EN
    , ST_PROGRAM
`endif
  } state_t;

endpackage

// File: rtl/code_lock_ctrl_equal_comparator_four.sv
// Four-bit equality compare between an entered digit and one stored code nibble.
module equal_comparator_four
  import code_lock_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  output logic                eq
);

  assign eq = (a == b);

endmodule

// File: rtl/code_lock_ctrl.sv
// Digit-entry code lock with failed-attempt lockout and optional code programming.
// Define CODE_LOCK_PROGRAM_EN to build the PROGRAM state, shadow register and prog_req path.
module code_lock_ctrl
  import code_lock_ctrl_pkg::*;
#(
  parameter int                              NUM_DIGITS     = 4,
  parameter int                              MAX_TRIES      = 3,
  parameter int                              LOCKOUT_CYCLES = 16,
  parameter logic [NUM_DIGITS*NIBBLE_W-1:0]  DEFAULT_CODE   = 16'h1234
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NIBBLE_W-1:0]           digit,
  input  logic                          digit_valid,
  input  logic                          clear,
  input  logic                          lock_req,
  input  logic                          prog_req,
  output logic                          unlock,
  output logic                          error,
  output logic                          locked_out,
  output logic [1:0]                    fail_cnt,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

  localparam int                 IDX_W      = $clog2(NUM_DIGITS);
  localparam int                 CODE_W     = NUM_DIGITS * NIBBLE_W;
  localparam int                 LCNT_W     = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [1:0]         FAIL_LIMIT = 2'(MAX_TRIES);
  localparam logic [LCNT_W-1:0]  LCNT_LOAD  = LCNT_W'(LOCKOUT_CYCLES - 1);

  state_t              state_q, state_d;
  logic                match_q;
  logic [LCNT_W-1:0]   lcnt_q;
  logic [CODE_W-1:0]   code_w;
  logic [NIBBLE_W-1:0] code_nib [NUM_DIGITS];
  logic [NIBBLE_W-1:0] sel_nib;
  logic                cur_eq, last_digit, entry_done, full_match, fail_evt, to_lockout;
  logic [1:0]          fail_inc;
  logic                unlock_d, error_d, locked_out_d;

`ifdef CODE_LOCK_PROGRAM_EN
  logic [CODE_W-1:0] code_q, shadow_q, shadow_nxt;
  assign code_w = code_q;
`else
  logic unused_prog_req;
  assign unused_prog_req = prog_req;
  assign code_w          = DEFAULT_CODE;
`endif

  // Digit 0 lives in the most significant nibble of the code word.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++)
      code_nib[i] = code_w[(NUM_DIGITS-1-i)*NIBBLE_W +: NIBBLE_W];
  end

  assign sel_nib = code_nib[digit_idx];

  equal_comparator_four u_cmp (
    .a  (digit),
    .b  (sel_nib),
    .eq (cur_eq)
  );

  assign last_digit = (digit_idx == LAST_IDX);
  assign entry_done = (state_q == ST_ENTRY) && digit_valid && !clear && last_digit;
  assign full_match = match_q && cur_eq;
  assign fail_evt   = entry_done && !full_match;
  assign fail_inc   = fail_cnt + 2'd1;
  assign to_lockout = fail_evt && (fail_inc == FAIL_LIMIT);

  // State register; the registered outputs follow the next state so they align with it.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ENTRY;
      unlock     <= 1'b0;
      error      <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state_q    <= state_d;
      unlock     <= unlock_d;
      error      <= error_d;
      locked_out <= locked_out_d;
    end
  end

  // NOTE: a default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ENTRY:
        if (entry_done) begin
          if (full_match)      state_d = ST_OPEN;
          else if (to_lockout) state_d = ST_LOCKOUT;
        end
      ST_OPEN:
        if (lock_req) state_d = ST_ENTRY;
`ifdef CODE_LOCK_PROGRAM_EN
        else if (prog_req) state_d = ST_PROGRAM;
      ST_PROGRAM:
        if (clear || (digit_valid && last_digit)) state_d = ST_OPEN;
`endif
      ST_LOCKOUT:
        if (lcnt_q == '0) state_d = ST_ENTRY;
      default: state_d = ST_ENTRY;
    endcase
  end

  always_comb begin
    unlock_d     = (state_d == ST_OPEN);
`ifdef CODE_LOCK_PROGRAM_EN
    unlock_d     = unlock_d || (state_d == ST_PROGRAM);
`endif
    locked_out_d = (state_d == ST_LOCKOUT);
    error_d      = fail_evt;
  end

`ifdef CODE_LOCK_PROGRAM_EN
  always_comb begin
    shadow_nxt = shadow_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (digit_idx == IDX_W'(i))
        shadow_nxt[(NUM_DIGITS-1-i)*NIBBLE_W +: NIBBLE_W] = digit;
  end
`endif

  // Entry datapath: digit index, sticky match, failure count, lockout timer, stored code.
  // NOTE: the stored code is a small register, not a memory, so it is reset to DEFAULT_CODE.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_idx <= '0;
      match_q   <= 1'b1;
      fail_cnt  <= '0;
      lcnt_q    <= '0;
`ifdef CODE_LOCK_PROGRAM_EN
      code_q    <= DEFAULT_CODE;
      shadow_q  <= DEFAULT_CODE;
`endif
    end else begin
      case (state_q)
        ST_ENTRY:
          if (clear) begin
            digit_idx <= '0;
            match_q   <= 1'b1;
          end else if (digit_valid) begin
            if (last_digit) begin
              digit_idx <= '0;
              match_q   <= 1'b1;
              fail_cnt  <= full_match ? 2'd0 : fail_inc;
              if (to_lockout) lcnt_q <= LCNT_LOAD;
            end else begin
              digit_idx <= digit_idx + IDX_W'(1);
              match_q   <= full_match;
            end
          end
        ST_OPEN: begin
          digit_idx <= '0;
          match_q   <= 1'b1;
        end
        ST_LOCKOUT:
          if (lcnt_q == '0) fail_cnt <= '0;
          else              lcnt_q   <= lcnt_q - LCNT_W'(1);
`ifdef CODE_LOCK_PROGRAM_EN
        ST_PROGRAM:
          if (clear) begin
            digit_idx <= '0;
          end else if (digit_valid) begin
            shadow_q <= shadow_nxt;
            if (last_digit) begin
              digit_idx <= '0;
              code_q    <= shadow_nxt;
            end else begin
              digit_idx <= digit_idx + IDX_W'(1);
            end
          end
`endif
        default: digit_idx <= '0;
      endcase
    end
  end

endmodule

// File: doc/code_lock_ctrl.md
CODE_LOCK_CTRL -- requirements
Module: code_lock_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, meaning digits per code (4-bit each).
REQ-002 SHALL have parameter MAX_TRIES, default 3, meaning consecutive failed entries before lockout.
REQ-003 SHALL have parameter LOCKOUT_CYCLES, default 16, meaning lockout duration in clk cycles.
REQ-004 SHALL have parameter DEFAULT_CODE, default 16'h1234, meaning the reset code, with digit 0 in the MS nibble.
REQ-005 SHALL have port clk  in  1  meaning the single clock; reset is synchronous and active-high.
REQ-006 SHALL have port rst  in  1  meaning synchronous, active-high reset.
REQ-007 SHALL have port digit  in  4  meaning the entered digit value.
REQ-008 SHALL have port digit_valid  in  1  meaning digit is sampled on this clk edge.
REQ-009 SHALL have port clear  in  1  meaning discard the partial entry.
REQ-010 SHALL have port lock_req  in  1  meaning relock from OPEN.
REQ-011 SHALL have port prog_req  in  1  meaning enter PROGRAM from OPEN.
REQ-012 SHALL have port unlock  out  1  meaning a level, high in OPEN.
REQ-013 SHALL have port error  out  1  meaning a one-cycle pulse on a failed entry.
REQ-014 SHALL have port locked_out  out  1  meaning a level, high in LOCKOUT.
REQ-015 SHALL have port fail_cnt  out  2  meaning consecutive failures so far.
REQ-016 SHALL have port digit_idx  out  $clog2(NUM_DIGITS)  meaning the position of the next digit.

Function
REQ-017 SHALL implement states ENTRY, OPEN, LOCKOUT, PROGRAM (PROGRAM only per REQ-031).
REQ-018 In ENTRY, each digit_valid SHALL compare digit with the stored nibble at digit_idx, AND the result into a sticky match flag, and increment digit_idx.
REQ-019 On the digit_valid where digit_idx==NUM_DIGITS-1, the block SHALL evaluate the match flag including the current digit, then reset digit_idx to 0 and the match flag to 1.
REQ-020 On a full match, the block SHALL go to OPEN next cycle, assert unlock, and clear fail_cnt.
REQ-021 On a mismatch, error SHALL pulse high for exactly one cycle and fail_cnt SHALL increment.
REQ-022 When the incremented fail_cnt equals MAX_TRIES, the block SHALL go to LOCKOUT and load the lockout counter with LOCKOUT_CYCLES-1.
REQ-023 Otherwise after a mismatch, the block SHALL stay in ENTRY.
REQ-024 A mismatch SHALL be reported only after all NUM_DIGITS are entered, never early.
REQ-025 clear in ENTRY SHALL reset digit_idx and the match flag without counting a failure.
REQ-026 clear SHALL have priority over a coincident digit_valid.
REQ-027 In LOCKOUT, digit_valid, clear, lock_req and prog_req SHALL be ignored.
REQ-028 In LOCKOUT, the counter SHALL decrement each cycle; at 0 the block SHALL return to ENTRY next cycle with fail_cnt=0, so locked_out is high for exactly LOCKOUT_CYCLES cycles.
REQ-029 In OPEN, lock_req SHALL return to ENTRY next cycle, with unlock low from that cycle.
REQ-030 In OPEN, lock_req SHALL win over a coincident prog_req, and digit_valid SHALL be ignored.
REQ-031 PROGRAM: each digit_valid SHALL write the nibble at digit_idx into a shadow register; after NUM_DIGITS digits the shadow SHALL commit atomically to the stored code and the state SHALL return to OPEN.
REQ-032 clear in PROGRAM SHALL abort to OPEN, leaving the stored code unchanged.
REQ-033 unlock SHALL stay high in PROGRAM.
REQ-034 The comparison SHALL be combinational on the registered code; all outputs SHALL be registered.

Reset
REQ-035 rst SHALL take priority over all inputs, including mid-entry, mid-lockout and mid-program.
REQ-036 After rst: state ENTRY, unlock=0, error=0, locked_out=0, fail_cnt=0, digit_idx=0, match flag=1, lockout counter=0.
REQ-037 After rst, the stored code SHALL equal DEFAULT_CODE, and any partial program SHALL be discarded.

Configuration
REQ-038 With macro CODE_LOCK_PROGRAM_EN defined, the PROGRAM state, shadow register and prog_req handling SHALL be present.
REQ-039 Without CODE_LOCK_PROGRAM_EN, the code SHALL be the constant DEFAULT_CODE, prog_req SHALL be ignored, and no PROGRAM state SHALL exist.

Structure
REQ-040 A shared package SHALL hold the state enum typedef and the nibble-width constant (4).
REQ-041 Each per-digit compare SHALL use one instance of sub-module equal_comparator_four (digit vs selected stored nibble); no other sub-modules.

Verification
REQ-042 After rst, enter 1,2,3,4 -> unlock=1 the cycle after the 4th digit, fail_cnt=0, error never asserted.
REQ-043 Enter 1,2,3,5 three times -> error pulses 3 times, with fail_cnt 1, 2, then locked_out=1 for 16 cycles; digits sent during lockout ignored; then fail_cnt=0.
REQ-044 Enter 1,2, then clear, then 1,2,3,4 -> unlock=1, fail_cnt=0.
REQ-045 (CODE_LOCK_PROGRAM_EN) In OPEN: prog_req, then 9,8,7,6, then lock_req; enter 1,2,3,4 -> error; enter 9,8,7,6 -> unlock.
REQ-046 Assert rst during the 3rd digit and during lockout cycle 5 -> all outputs at reset values next cycle, and code 1234 accepted afterwards.
REQ-047 In OPEN, assert lock_req and prog_req together -> ENTRY, unlock=0, stored code unchanged.
